stump_sequencer: RTL and testbench

- Sequencing stage directly upstream of the Stump control decoder.
- Owns the FETCH/EXECUTE/MEMORY state register, the instruction register (IR) and the condition-code register (CC); these feed the decoder's state, ir and cc inputs.
- Inserts memory wait states via an acknowledge handshake.
- Evaluates branch conditions and produces the write-back qualifier the datapath ANDs with the decoder's reg_write.

---
 rtl/stump_sequencer.sv | 131 +++++++++++++
 tb/tb_stump_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stump_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stump_sequencer
// Purpose  : FETCH/EXECUTE/MEMORY sequencing, IR and CC registers, memory
//            wait-state insertion and branch/write-back qualification.
// Revision : 1.0 - initial release
// ============================================================================
module stump_sequencer #(
    parameter logic [15:0] RST_IR = 16'h0000,
    parameter logic [3:0]  RST_CC = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        cc_en,
    input  logic [3:0]  flags_in,
    output logic [1:0]  state,
    output logic [15:0] ir,
    output logic [3:0]  cc,
    output logic        stall,
    output logic        branch_taken,
    output logic        wb_en,
    output logic        instr_done
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_EXECUTE = 2'b01,
        S_MEMORY  = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    localparam logic [2:0] OP_LDST = 3'b110;
    localparam logic [2:0] OP_BCC  = 3'b111;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [3:0]  cc_q, cc_d;

    logic [2:0] w_opcode;
    logic       w_illegal;
    logic       w_n, w_z, w_v, w_c;
    logic       w_cond_base;
    logic       w_cond_true;

    assign w_opcode  = ir_q[15:13];
    assign w_illegal = (state_q == S_ILLEGAL);
    assign {w_n, w_z, w_v, w_c} = cc_q;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cc_d    = cc_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_d = (w_opcode == OP_LDST) ? S_MEMORY : S_FETCH;
                if (cc_en && (w_opcode != OP_BCC)) begin
                    cc_d = flags_in;
                end
            end
            S_MEMORY: begin
                if (mem_ack) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= RST_IR;
            cc_q    <= RST_CC;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cc_q    <= cc_d;
        end
    end

    // Conditions come in pairs: odd code is the base test, even code its inverse.
    always_comb begin
        w_cond_base = 1'b0;
        case (ir_q[11:9])
            3'd0: w_cond_base = 1'b0;
            3'd1: w_cond_base = w_c | w_z;
            3'd2: w_cond_base = w_c;
            3'd3: w_cond_base = w_z;
            3'd4: w_cond_base = w_v;
            3'd5: w_cond_base = w_n;
            3'd6: w_cond_base = w_v ^ w_n;
            3'd7: w_cond_base = (w_v ^ w_n) | w_z;
            default: w_cond_base = 1'b0;
        endcase
        w_cond_true = ir_q[8] ? w_cond_base : ~w_cond_base;
    end

    always_comb begin
        stall        = 1'b0;
        wb_en        = 1'b0;
        instr_done   = 1'b0;
        branch_taken = 1'b0;
        if (!w_illegal) begin
            branch_taken = w_cond_true;
            stall        = ((state_q == S_FETCH) || (state_q == S_MEMORY)) && !mem_ack;
            if (stall) begin
                wb_en = 1'b0;
            end else if ((state_q == S_EXECUTE) && (w_opcode == OP_BCC)) begin
                wb_en = w_cond_true;
            end else begin
                wb_en = 1'b1;
            end
            instr_done = ((state_q == S_EXECUTE) && (w_opcode != OP_LDST)) ||
                         ((state_q == S_MEMORY) && mem_ack);
        end
    end

    assign state = w_illegal ? 2'b00  : state_q;
    assign ir    = w_illegal ? 16'h0  : ir_q;
    assign cc    = w_illegal ? 4'b0   : cc_q;

endmodule
`default_nettype wire

// File: tb/tb_stump_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stump_sequencer
// Purpose  : Self-checking bench for stump_sequencer with an IR scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stump_sequencer;

    localparam logic [15:0] C_RST_IR = 16'hA5A5;
    localparam logic [3:0]  C_RST_CC = 4'b1010;

    logic        clk;
    logic        rst;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        cc_en;
    logic [3:0]  flags_in;
    logic [1:0]  state;
    logic [15:0] ir;
    logic [3:0]  cc;
    logic        stall;
    logic        branch_taken;
    logic        wb_en;
    logic        instr_done;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] sb_q[$];

    stump_sequencer #(.RST_IR(C_RST_IR), .RST_CC(C_RST_CC)) dut (
        .clk(clk), .rst(rst), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cc_en(cc_en), .flags_in(flags_in), .state(state), .ir(ir), .cc(cc),
        .stall(stall), .branch_taken(branch_taken), .wb_en(wb_en),
        .instr_done(instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every retiring instruction must carry the IR that was fetched for it.
    always @(negedge clk) begin
        if (!rst && instr_done) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_retire: instr_done with ir=%h but no instruction outstanding", ir);
            end else begin
                logic [15:0] exp_ir;
                exp_ir = sb_q.pop_front();
                if (ir !== exp_ir) begin
                    n_errors++;
                    $display("FAIL sb_retire_ir: got %h expected %h", ir, exp_ir);
                end
            end
        end
    end

    function automatic logic ref_branch(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, v, c;
        {n, z, v, c} = f;
        case (cond)
            4'd0:  return 1'b1;
            4'd1:  return 1'b0;
            4'd2:  return ~(c | z);
            4'd3:  return c | z;
            4'd4:  return ~c;
            4'd5:  return c;
            4'd6:  return ~z;
            4'd7:  return z;
            4'd8:  return ~v;
            4'd9:  return v;
            4'd10: return ~n;
            4'd11: return n;
            4'd12: return ~(v ^ n);
            4'd13: return v ^ n;
            4'd14: return ~((v ^ n) | z);
            default: return (v ^ n) | z;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [15:0] instr);
        mem_ack   = 1'b1;
        mem_rdata = instr;
        sb_q.push_back(instr);
        tick();
    endtask

    task automatic do_exec(input logic en, input logic [3:0] fl);
        mem_ack  = 1'b0;
        cc_en    = en;
        flags_in = fl;
        tick();
        cc_en    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h0; cc_en = 1'b0; flags_in = 4'h0;
        tick(); tick();
        n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL reset_state: got %b expected 00", state); end
        n_checks++; if (ir !== C_RST_IR) begin n_errors++; $display("FAIL reset_ir: got %h expected %h", ir, C_RST_IR); end
        n_checks++; if (cc !== C_RST_CC) begin n_errors++; $display("FAIL reset_cc: got %b expected %b", cc, C_RST_CC); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        mem_ack = 1'b0;
        rst = 1'b0;
        tick();
        n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL reset_release_state: got %b expected 00", state); end
    endtask

    task automatic test_add_stream();
        mem_ack = 1'b1; mem_rdata = 16'h0000; cc_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (state !== ((i % 2) ? 2'b01 : 2'b00)) begin n_errors++; $display("FAIL add_state[%0d]: got %b expected %b", i, state, (i % 2) ? 2'b01 : 2'b00); end
            n_checks++; if (wb_en !== 1'b1) begin n_errors++; $display("FAIL add_wb_en[%0d]: got %b expected 1", i, wb_en); end
            n_checks++; if (instr_done !== ((i % 2) == 1)) begin n_errors++; $display("FAIL add_done[%0d]: got %b expected %b", i, instr_done, (i % 2) == 1); end
            if ((i % 2) == 0) sb_q.push_back(16'h0000);
            tick();
        end
    endtask

    task automatic test_wait_ldst();
        mem_ack = 1'b0; mem_rdata = 16'hC000;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL wait_stall[%0d]: got %b expected 1", i, stall); end
            n_checks++; if (wb_en !== 1'b0) begin n_errors++; $display("FAIL wait_wb_en[%0d]: got %b expected 0", i, wb_en); end
            n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL wait_state[%0d]: got %b expected 00", i, state); end
            tick();
        end
        mem_ack = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL wait_ack_stall: got %b expected 0", stall); end
        sb_q.push_back(16'hC000);
        tick();
        mem_ack = 1'b0;
        #1;
        n_checks++; if (ir !== 16'hC000) begin n_errors++; $display("FAIL ldst_ir: got %h expected c000", ir); end
        n_checks++; if (state !== 2'b01) begin n_errors++; $display("FAIL ldst_exec_state: got %b expected 01", state); end
        n_checks++; if (instr_done !== 1'b0) begin n_errors++; $display("FAIL ldst_exec_done: got %b expected 0", instr_done); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL ldst_exec_stall: got %b expected 0", stall); end
        tick();
        n_checks++; if (state !== 2'b10) begin n_errors++; $display("FAIL ldst_mem_state: got %b expected 10", state); end
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL ldst_mem_stall: got %b expected 1", stall); end
        n_checks++; if (instr_done !== 1'b0) begin n_errors++; $display("FAIL ldst_mem_done_early: got %b expected 0", instr_done); end
        tick();
        n_checks++; if (state !== 2'b10) begin n_errors++; $display("FAIL ldst_mem_hold: got %b expected 10", state); end
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        #1;
        n_checks++; if (instr_done !== 1'b1) begin n_errors++; $display("FAIL ldst_mem_done: got %b expected 1", instr_done); end
        n_checks++; if (wb_en !== 1'b1) begin n_errors++; $display("FAIL ldst_mem_wb_en: got %b expected 1", wb_en); end
        tick();
        mem_ack = 1'b0;
        #1;
        n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL ldst_back_fetch: got %b expected 00", state); end
        n_checks++; if (ir !== 16'hC000) begin n_errors++; $display("FAIL ldst_ir_hold: got %h expected c000", ir); end
    endtask

    task automatic test_cc_update();
        do_fetch(16'h0800);
        do_exec(1'b1, 4'b0100);
        n_checks++; if (cc !== 4'b0100) begin n_errors++; $display("FAIL cc_update: got %b expected 0100", cc); end
        do_fetch(16'hE800);
        do_exec(1'b1, 4'b1111);
        n_checks++; if (cc !== 4'b0100) begin n_errors++; $display("FAIL cc_bcc_hold: got %b expected 0100", cc); end
    endtask

    task automatic test_branch();
        do_fetch(16'hE700);
        #1;
        n_checks++; if (branch_taken !== 1'b1) begin n_errors++; $display("FAIL br_z_taken: got %b expected 1", branch_taken); end
        n_checks++; if (wb_en !== 1'b1) begin n_errors++; $display("FAIL br_z_wb_en: got %b expected 1", wb_en); end
        do_exec(1'b0, 4'b0000);
        do_fetch(16'h0000);
        do_exec(1'b1, 4'b0000);
        do_fetch(16'hE700);
        #1;
        n_checks++; if (branch_taken !== 1'b0) begin n_errors++; $display("FAIL br_nz_taken: got %b expected 0", branch_taken); end
        n_checks++; if (wb_en !== 1'b0) begin n_errors++; $display("FAIL br_nz_wb_en: got %b expected 0", wb_en); end
        n_checks++; if (instr_done !== 1'b1) begin n_errors++; $display("FAIL br_nz_done: got %b expected 1", instr_done); end
        do_exec(1'b0, 4'b0000);
    endtask

    task automatic test_sweep();
        for (int f = 0; f < 16; f++) begin
            do_fetch(16'h0000);
            do_exec(1'b1, 4'(f));
            for (int cnd = 0; cnd < 16; cnd++) begin
                do_fetch({4'b1110, 4'(cnd), 8'h00});
                #1;
                n_checks++;
                if (branch_taken !== ref_branch(4'(cnd), 4'(f))) begin
                    n_errors++;
                    $display("FAIL sweep cond=%0d cc=%b: got %b expected %b", cnd, 4'(f), branch_taken, ref_branch(4'(cnd), 4'(f)));
                end
                do_exec(1'b1, ~4'(f));
            end
            n_checks++; if (cc !== 4'(f)) begin n_errors++; $display("FAIL sweep_cc_hold: got %b expected %b", cc, 4'(f)); end
        end
    endtask

    task automatic test_reset_mid();
        do_fetch(16'hC000);
        do_exec(1'b1, 4'b0110);
        n_checks++; if (cc !== 4'b0110) begin n_errors++; $display("FAIL mid_cc_pre: got %b expected 0110", cc); end
        n_checks++; if (state !== 2'b10) begin n_errors++; $display("FAIL mid_state_pre: got %b expected 10", state); end
        rst = 1'b1;
        #1;
        n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL mid_async_state: got %b expected 00", state); end
        n_checks++; if (cc !== C_RST_CC) begin n_errors++; $display("FAIL mid_async_cc: got %b expected %b", cc, C_RST_CC); end
        n_checks++; if (ir !== C_RST_IR) begin n_errors++; $display("FAIL mid_async_ir: got %h expected %h", ir, C_RST_IR); end
        sb_q.delete();
        tick(); tick();
        rst = 1'b0;
        do_fetch(16'h2000);
        mem_ack = 1'b0;
        #1;
        n_checks++; if (state !== 2'b01) begin n_errors++; $display("FAIL mid_refetch_state: got %b expected 01", state); end
        n_checks++; if (ir !== 16'h2000) begin n_errors++; $display("FAIL mid_refetch_ir: got %h expected 2000", ir); end
        n_checks++; if (instr_done !== 1'b1) begin n_errors++; $display("FAIL mid_refetch_done: got %b expected 1", instr_done); end
        tick();
        n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL mid_refetch_back: got %b expected 00", state); end
    endtask

    initial begin
        test_reset();
        test_add_stream();
        test_wait_ldst();
        test_cc_update();
        test_branch();
        test_sweep();
        test_reset_mid();
        tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: %0d instructions never retired, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
